hilo_mdu: RTL and testbench

HILO_MDU -- requirements
Module: hilo_mdu

---
 rtl/hilo_mdu_if.sv | 28 ++
 rtl/hilo_mdu.sv | 179 +++++++++++++++++
 tb/tb_hilo_mdu.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_mdu_if.sv
// Request/response bundle between a requester and the HI/LO multiply-divide unit.
// The requester drives start/op/operands; the unit returns HI/LO, the read mux and status.
interface hilo_mdu_if #(
  parameter int unsigned N = 4
) ();
  logic         start;
  logic [2:0]   op;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] mul_lo;
  logic [N-1:0] mul_hi;
  logic [N-1:0] hi;
  logic [N-1:0] lo;
  logic [N-1:0] rdata;
  logic         busy;
  logic         done;
  logic         dbz;

  modport master (
    output start, op, A, B, mul_lo, mul_hi,
    input  hi, lo, rdata, busy, done, dbz
  );

  modport slave (
    input  start, op, A, B, mul_lo, mul_hi,
    output hi, lo, rdata, busy, done, dbz
  );
endinterface

// File: rtl/hilo_mdu.sv
// HI/LO register pair with multiply write-back, moves and an iterative
// restoring divider (signed and unsigned), one quotient bit per cycle.
module hilo_mdu #(
  parameter int unsigned N = 4
) (
  input  logic       clk,
  input  logic       rst,
  hilo_mdu_if.slave  bus
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] OP_WRMUL = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MFHI  = 3'b110;
  localparam logic [2:0] OP_MFLO  = 3'b111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIV_RUN = 2'd1,
    DIV_FIX = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   hi_q, hi_d;
  logic [N-1:0]   lo_q, lo_d;
  logic [N-1:0]   quo_q, quo_d;
  logic [N-1:0]   rem_q, rem_d;
  logic [N-1:0]   dvs_q, dvs_d;
  logic [N-1:0]   araw_q, araw_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           qneg_q, qneg_d;
  logic           rneg_q, rneg_d;
  logic           bz_q, bz_d;
  logic           done_q, done_d;
  logic           dbz_q, dbz_d;
  logic           busy_q, busy_d;

  logic           div_req;
  logic           a_neg;
  logic           b_neg;
  logic [N:0]     rem_sh;
  logic [N:0]     rem_diff;
  logic [N-1:0]   fix_quo;
  logic [N-1:0]   fix_rem;

  assign div_req = bus.start && ((bus.op == OP_DIVU) || (bus.op == OP_DIV));
  assign a_neg   = (bus.op == OP_DIV) && bus.A[N-1];
  assign b_neg   = (bus.op == OP_DIV) && bus.B[N-1];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (div_req) state_d = DIV_RUN;
      DIV_RUN: if (cnt_q == CW'(N - 1)) state_d = DIV_FIX;
      DIV_FIX: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output logic
  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    araw_d  = araw_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    bz_d    = bz_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    busy_d  = (state_d != IDLE);

    // Shift in the next dividend bit and trial-subtract; remainder always fits N bits.
    rem_sh   = {rem_q, quo_q[N-1]};
    rem_diff = rem_sh - {1'b0, dvs_q};
    fix_quo  = qneg_q ? (~quo_q + N'(1)) : quo_q;
    fix_rem  = rneg_q ? (~rem_q + N'(1)) : rem_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          unique case (bus.op)
            OP_WRMUL: begin
              hi_d   = bus.mul_hi;
              lo_d   = bus.mul_lo;
              done_d = 1'b1;
            end
            OP_MTHI: begin
              hi_d   = bus.A;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = bus.A;
              done_d = 1'b1;
            end
            OP_DIVU, OP_DIV: begin
              quo_d  = a_neg ? (~bus.A + N'(1)) : bus.A;
              dvs_d  = b_neg ? (~bus.B + N'(1)) : bus.B;
              rem_d  = '0;
              cnt_d  = '0;
              araw_d = bus.A;
              qneg_d = a_neg ^ b_neg;
              rneg_d = a_neg;
              bz_d   = (bus.B == '0);
            end
            default: ;
          endcase
        end
      end
      DIV_RUN: begin
        cnt_d = cnt_q + CW'(1);
        quo_d = {quo_q[N-2:0], ~rem_diff[N]};
        rem_d = rem_diff[N] ? rem_sh[N-1:0] : rem_diff[N-1:0];
      end
      DIV_FIX: begin
        done_d = 1'b1;
        dbz_d  = bz_q;
        hi_d   = bz_q ? araw_q : fix_rem;
        lo_d   = bz_q ? '1     : fix_quo;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      araw_q <= '0;
      cnt_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      bz_q   <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      araw_q <= araw_d;
      cnt_q  <= cnt_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      bz_q   <= bz_d;
      done_q <= done_d;
      dbz_q  <= dbz_d;
      busy_q <= busy_d;
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.dbz   = dbz_q;
  assign bus.rdata = (bus.op == OP_MFHI) ? hi_q :
                     (bus.op == OP_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_hilo_mdu.sv
// Scenario bench for hilo_mdu: expected HI/LO/dbz are queued when a request is
// driven and compared when done is observed.
module tb_hilo_mdu;

  localparam int unsigned N = 4;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_WRMUL = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MFHI  = 3'b110;
  localparam logic [2:0] OP_MFLO  = 3'b111;

  typedef struct packed {
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         dbz;
  } exp_t;

  typedef struct packed {
    logic [2:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    exp_t         e;
  } vec_t;

  localparam int NV = 9;

  logic clk = 1'b0;
  logic rst;

  hilo_mdu_if #(.N(N)) bus ();
  hilo_mdu #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  exp_t         sb[$];
  int           n_cmp = 0;
  int           n_err = 0;
  logic [N-1:0] m_hi, m_lo;

  // {op, A, B, {hi, lo, dbz}}
  vec_t tbl [NV] = '{
    '{OP_DIVU, 4'd13, 4'd4, '{4'h1, 4'h3, 1'b0}},
    '{OP_DIV,  4'h9,  4'h2, '{4'hF, 4'hD, 1'b0}},
    '{OP_DIVU, 4'h9,  4'h0, '{4'h9, 4'hF, 1'b1}},
    '{OP_DIV,  4'h8,  4'hF, '{4'h0, 4'h8, 1'b0}},
    '{OP_DIV,  4'h7,  4'hE, '{4'h1, 4'hD, 1'b0}},
    '{OP_DIV,  4'hA,  4'h0, '{4'hA, 4'hF, 1'b1}},
    '{OP_DIVU, 4'hF,  4'h1, '{4'h0, 4'hF, 1'b0}},
    '{OP_DIVU, 4'h3,  4'h5, '{4'h3, 4'h0, 1'b0}},
    '{OP_DIV,  4'hA,  4'h3, '{4'h0, 4'hE, 1'b0}}
  };

  function automatic exp_t model_div(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    int   ai, bi;
    e.dbz = 1'b0;
    if (b == '0) begin
      e.hi  = a;
      e.lo  = '1;
      e.dbz = 1'b1;
    end else begin
      if (op == OP_DIV) begin
        ai = int'($signed(a));
        bi = int'($signed(b));
      end else begin
        ai = int'(a);
        bi = int'(b);
      end
      e.lo = N'(ai / bi);
      e.hi = N'(ai % bi);
    end
    return e;
  endfunction

  task automatic push(input exp_t e);
    sb.push_back(e);
    m_hi = e.hi;
    m_lo = e.lo;
  endtask

  task automatic drive_start(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                             input logic [N-1:0] mh, input logic [N-1:0] ml);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = b; bus.mul_hi = mh; bus.mul_lo = ml;
    @(negedge clk);
    bus.start = 1'b0; bus.op = OP_NOP; bus.A = ~a; bus.B = ~b; bus.mul_hi = ~mh; bus.mul_lo = ~ml;
  endtask

  // Waits (bounded) for done; lat counts edges after the accepting edge.
  task automatic wait_done(input int base, output int lat, output int bc, output bit ok);
    lat = -1; bc = 0; ok = 1'b0;
    for (int i = 0; i < 4 * N + 8; i++) begin
      if (bus.done === 1'b1) begin
        ok  = 1'b1;
        lat = base + i;
        break;
      end
      if (bus.busy === 1'b1) bc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b1; bus.op = OP_WRMUL; bus.mul_hi = '1; bus.mul_lo = '1;
    bus.A = '0; bus.B = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.hi, bus.lo, bus.busy, bus.done, bus.dbz} !== '0) begin
      n_err++;
      $display("FAIL reset: hi/lo/busy/done/dbz got %h/%h/%b/%b/%b exp 0/0/0/0/0",
               bus.hi, bus.lo, bus.busy, bus.done, bus.dbz);
    end
    rst = 1'b0; bus.start = 1'b0; bus.op = OP_NOP;
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    n_cmp++;
    if ({bus.hi, bus.lo, bus.done} !== '0) begin
      n_err++;
      $display("FAIL reset_release: hi/lo/done got %h/%h/%b exp 0/0/0", bus.hi, bus.lo, bus.done);
    end
  endtask

  task automatic test_wrmul();
    exp_t e;
    int   lat, bc;
    bit   ok;
    push('{4'h1, 4'hE, 1'b0});
    drive_start(OP_WRMUL, 4'h0, 4'h0, 4'h1, 4'hE);
    wait_done(0, lat, bc, ok);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || {bus.hi, bus.lo, bus.dbz} !== e) begin
      n_err++;
      $display("FAIL wrmul: ok=%b hi/lo/dbz got %h/%h/%b exp %h/%h/%b", ok, bus.hi, bus.lo, bus.dbz, e.hi, e.lo, e.dbz);
    end
    n_cmp++;
    if (lat != 0) begin
      n_err++;
      $display("FAIL wrmul_latency: got %0d exp 0", lat);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL wrmul_done_width: done got %b exp 0", bus.done);
    end
  endtask

  task automatic test_moves();
    exp_t e;
    int   lat, bc;
    bit   ok;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) push('{4'h6, m_lo, 1'b0});
      else        push('{m_hi, 4'h9, 1'b0});
      drive_start((i == 0) ? OP_MTHI : OP_MTLO, (i == 0) ? 4'h6 : 4'h9, 4'h0, 4'h0, 4'h0);
      wait_done(0, lat, bc, ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || lat != 0 || {bus.hi, bus.lo, bus.dbz} !== e) begin
        n_err++;
        $display("FAIL move[%0d]: ok=%b lat=%0d hi/lo got %h/%h exp %h/%h", i, ok, lat, bus.hi, bus.lo, e.hi, e.lo);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_read_nop();
    bus.start = 1'b1; bus.op = OP_MFHI;
    #1;
    n_cmp++;
    if (bus.rdata !== m_hi) begin
      n_err++;
      $display("FAIL rdata_mfhi: got %h exp %h", bus.rdata, m_hi);
    end
    @(negedge clk);
    bus.op = OP_MFLO;
    #1;
    n_cmp++;
    if (bus.rdata !== m_lo || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL rdata_mflo: rdata/done/busy got %h/%b/%b exp %h/0/0", bus.rdata, bus.done, bus.busy, m_lo);
    end
    @(negedge clk);
    bus.op = OP_NOP;
    #1;
    n_cmp++;
    if (bus.rdata !== '0 || bus.done !== 1'b0 || bus.hi !== m_hi || bus.lo !== m_lo) begin
      n_err++;
      $display("FAIL nop: rdata/done/hi/lo got %h/%b/%h/%h exp 0/0/%h/%h", bus.rdata, bus.done, bus.hi, bus.lo, m_hi, m_lo);
    end
    @(negedge clk);
    bus.start = 1'b0;
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL nop_done: done got %b exp 0", bus.done);
    end
  endtask

  task automatic test_div_table();
    for (int i = 0; i < NV; i++) begin
      exp_t e;
      int   lat, bc;
      bit   ok;
      push(tbl[i].e);
      drive_start(tbl[i].op, tbl[i].a, tbl[i].b, 4'h0, 4'h0);
      wait_done(0, lat, bc, ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || {bus.hi, bus.lo, bus.dbz} !== e) begin
        n_err++;
        $display("FAIL div[%0d]: ok=%b hi/lo/dbz got %h/%h/%b exp %h/%h/%b", i, ok, bus.hi, bus.lo, bus.dbz, e.hi, e.lo, e.dbz);
      end
      n_cmp++;
      if (lat != N + 1 || bc != N + 1) begin
        n_err++;
        $display("FAIL div_timing[%0d]: latency/busy got %0d/%0d exp %0d/%0d", i, lat, bc, N + 1, N + 1);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.done !== 1'b0 || bus.dbz !== 1'b0) begin
        n_err++;
        $display("FAIL div_pulse[%0d]: done/dbz got %b/%b exp 0/0", i, bus.done, bus.dbz);
      end
    end
  endtask

  task automatic test_random_div();
    for (int i = 0; i < 10; i++) begin
      exp_t         e;
      logic [2:0]   op;
      logic [N-1:0] a, b;
      int           lat, bc;
      bit           ok;
      op = ($urandom_range(1, 0) == 0) ? OP_DIVU : OP_DIV;
      a  = N'($urandom_range(15, 0));
      b  = N'($urandom_range(15, 0));
      push(model_div(op, a, b));
      drive_start(op, a, b, 4'h0, 4'h0);
      wait_done(0, lat, bc, ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || lat != N + 1 || {bus.hi, bus.lo, bus.dbz} !== e) begin
        n_err++;
        $display("FAIL rand_div[%0d] op=%0d a=%h b=%h: ok=%b lat=%0d hi/lo/dbz got %h/%h/%b exp %h/%h/%b",
                 i, op, a, b, ok, lat, bus.hi, bus.lo, bus.dbz, e.hi, e.lo, e.dbz);
      end
    end
  endtask

  task automatic test_busy_ignore();
    exp_t         e;
    logic [N-1:0] pre_hi, pre_lo;
    int           lat, bc;
    bit           ok;
    push('{4'h6, 4'h5, 1'b0});
    drive_start(OP_MTHI, 4'h6, 4'h0, 4'h0, 4'h0);
    @(negedge clk);
    drive_start(OP_MTLO, 4'h5, 4'h0, 4'h0, 4'h0);
    @(negedge clk);
    void'(sb.pop_front());
    pre_hi = m_hi; pre_lo = m_lo;
    push('{4'h1, 4'h3, 1'b0});
    drive_start(OP_DIVU, 4'd13, 4'd4, 4'h0, 4'h0);
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MTHI; bus.A = 4'h7;
    @(negedge clk);
    bus.start = 1'b0; bus.op = OP_MFHI;
    #1;
    n_cmp++;
    if (bus.rdata !== pre_hi || bus.hi !== pre_hi) begin
      n_err++;
      $display("FAIL busy_rdata_hi: rdata/hi got %h/%h exp %h/%h", bus.rdata, bus.hi, pre_hi, pre_hi);
    end
    bus.op = OP_MFLO;
    #1;
    n_cmp++;
    if (bus.rdata !== pre_lo) begin
      n_err++;
      $display("FAIL busy_rdata_lo: got %h exp %h", bus.rdata, pre_lo);
    end
    bus.op = OP_NOP;
    wait_done(2, lat, bc, ok);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || lat != N + 1 || {bus.hi, bus.lo, bus.dbz} !== e) begin
      n_err++;
      $display("FAIL busy_ignore: ok=%b lat=%0d hi/lo got %h/%h exp %h/%h", ok, lat, bus.hi, bus.lo, e.hi, e.lo);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.hi !== 4'h1 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL busy_no_queue: hi/done/busy got %h/%b/%b exp 1/0/0", bus.hi, bus.done, bus.busy);
    end
  endtask

  task automatic test_rst_abort();
    int seen;
    drive_start(OP_DIVU, 4'd13, 4'd4, 4'h0, 4'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.hi !== '0 || bus.lo !== '0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL rst_abort: busy/hi/lo/done got %b/%h/%h/%b exp 0/0/0/0", bus.busy, bus.hi, bus.lo, bus.done);
    end
    seen = 0;
    for (int i = 0; i < N + 4; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen != 0 || bus.hi !== '0 || bus.lo !== '0) begin
      n_err++;
      $display("FAIL rst_abort_quiet: stray cycles got %0d exp 0, hi/lo %h/%h exp 0/0", seen, bus.hi, bus.lo);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat, bc;
    bit   ok;
    push('{4'h1, 4'h3, 1'b0});
    drive_start(OP_DIVU, 4'd13, 4'd4, 4'h0, 4'h0);
    wait_done(0, lat, bc, ok);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || {bus.hi, bus.lo, bus.dbz} !== e) begin
      n_err++;
      $display("FAIL b2b_first: ok=%b hi/lo got %h/%h exp %h/%h", ok, bus.hi, bus.lo, e.hi, e.lo);
    end
    push('{4'hF, 4'hD, 1'b0});
    bus.start = 1'b1; bus.op = OP_DIV; bus.A = 4'h9; bus.B = 4'h2;
    @(negedge clk);
    bus.start = 1'b0; bus.op = OP_NOP; bus.A = 4'h0; bus.B = 4'h0;
    n_cmp++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_accept: done/busy got %b/%b exp 0/1", bus.done, bus.busy);
    end
    wait_done(0, lat, bc, ok);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || lat != N + 1 || {bus.hi, bus.lo, bus.dbz} !== e) begin
      n_err++;
      $display("FAIL b2b_second: ok=%b lat=%0d hi/lo got %h/%h exp %h/%h", ok, lat, bus.hi, bus.lo, e.hi, e.lo);
    end
    @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0; bus.op = OP_NOP; bus.A = '0; bus.B = '0;
    bus.mul_hi = '0; bus.mul_lo = '0;
    rst = 1'b1;
    m_hi = '0; m_lo = '0;
    test_reset();
    test_wrmul();
    test_moves();
    test_read_nop();
    test_div_table();
    test_random_div();
    test_busy_ignore();
    test_rst_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
